id_ex_pipe_reg: RTL and testbench

Parametrised ID/EX pipeline register for the pipelined MIPS datapath. It sits between the decode stage (register file, sign extender, control unit) and the execute stage. It captures the WB/M/EX control groups, next PC, both read operands, the sign-extended immediate and the two destination-register fields on each clock edge. Unlike the fixed-width latch, it supports stall (hold), flush (bubble insertion), a valid bit and a saturating stall-cycle counter.

---
 rtl/id_ex_pipe_reg_if.sv | 60 ++++++
 rtl/id_ex_pipe_reg.sv | 112 +++++++++++
 tb/tb_id_ex_pipe_reg.sv | 206 ++++++++++++++++++++
 3 files changed

// File: rtl/id_ex_pipe_reg_if.sv
// ID/EX pipeline register bus.
// Groups the decode-side inputs (stall, flush, valid, control groups, operands)
// and the registered execute-side outputs of id_ex_pipe_reg.
// master: decode/hazard side that drives the stage inputs and observes outputs.
// slave : the pipeline register itself.
interface id_ex_pipe_reg_if #(
    parameter int DATA_W = 32,
    parameter int REG_W  = 5,
    parameter int WB_W   = 2,
    parameter int M_W    = 3,
    parameter int EX_W   = 4,
    parameter int CNT_W  = 16
);
    // Hazard / handshake controls
    logic              stall;
    logic              flush;
    logic              in_valid;

    // Decode-stage inputs
    logic [WB_W-1:0]   ctlwb_out;
    logic [M_W-1:0]    ctlm_out;
    logic [EX_W-1:0]   ctlex_out;
    logic [DATA_W-1:0] npc;
    logic [DATA_W-1:0] readdat1;
    logic [DATA_W-1:0] readdat2;
    logic [DATA_W-1:0] signext_out;
    logic [REG_W-1:0]  instr_2016;
    logic [REG_W-1:0]  instr_1511;

    // Registered execute-stage outputs
    logic [WB_W-1:0]   wb_ctlout;
    logic [M_W-1:0]    m_ctlout;
    logic [EX_W-1:0]   ex_ctlout;
    logic [DATA_W-1:0] npcout;
    logic [DATA_W-1:0] rdata1out;
    logic [DATA_W-1:0] rdata2out;
    logic [DATA_W-1:0] s_extendout;
    logic [REG_W-1:0]  instrout_2016;
    logic [REG_W-1:0]  instrout_1511;
    logic              valid_out;
    logic [CNT_W-1:0]  stall_cnt;

    modport master (
        output stall, flush, in_valid,
        output ctlwb_out, ctlm_out, ctlex_out,
        output npc, readdat1, readdat2, signext_out, instr_2016, instr_1511,
        input  wb_ctlout, m_ctlout, ex_ctlout,
        input  npcout, rdata1out, rdata2out, s_extendout, instrout_2016, instrout_1511,
        input  valid_out, stall_cnt
    );

    modport slave (
        input  stall, flush, in_valid,
        input  ctlwb_out, ctlm_out, ctlex_out,
        input  npc, readdat1, readdat2, signext_out, instr_2016, instr_1511,
        output wb_ctlout, m_ctlout, ex_ctlout,
        output npcout, rdata1out, rdata2out, s_extendout, instrout_2016, instrout_1511,
        output valid_out, stall_cnt
    );
endinterface

// File: rtl/id_ex_pipe_reg.sv
// ID/EX pipeline register for the pipelined MIPS datapath.
// Captures WB/M/EX control, next PC, both read operands, the sign-extended
// immediate and the rt/rd fields each rising edge, with stall (hold), flush
// (bubble), a valid bit and a saturating stall-cycle counter.
// Per-edge priority: reset > flush > stall > load.
// Optional macro IDEX_FLUSH_ZERO_DATA_EN: when defined, flush also clears the
// data fields; otherwise flush clears only control and valid, and data holds.
module id_ex_pipe_reg #(
    parameter int DATA_W = 32,
    parameter int REG_W  = 5,
    parameter int WB_W   = 2,
    parameter int M_W    = 3,
    parameter int EX_W   = 4,
    parameter int CNT_W  = 16
) (
    input  logic           clk,
    input  logic           rst_n,
    id_ex_pipe_reg_if.slave if_idex
);
    logic [WB_W-1:0]   r_wb;
    logic [M_W-1:0]    r_m;
    logic [EX_W-1:0]   r_ex;
    logic [DATA_W-1:0] r_npc;
    logic [DATA_W-1:0] r_rdata1;
    logic [DATA_W-1:0] r_rdata2;
    logic [DATA_W-1:0] r_sext;
    logic [REG_W-1:0]  r_rt;
    logic [REG_W-1:0]  r_rd;
    logic              r_valid;
    logic [CNT_W-1:0]  r_stall_cnt;

    // A non-valid instruction enters as a bubble: its control is forced to zero
    // so nothing downstream writes registers or memory.
    logic [WB_W-1:0]   w_wb_ld;
    logic [M_W-1:0]    w_m_ld;
    logic [EX_W-1:0]   w_ex_ld;
    logic              w_cnt_sat;
    logic              w_cnt_inc;

    assign w_wb_ld   = if_idex.in_valid ? if_idex.ctlwb_out : '0;
    assign w_m_ld    = if_idex.in_valid ? if_idex.ctlm_out  : '0;
    assign w_ex_ld   = if_idex.in_valid ? if_idex.ctlex_out : '0;
    assign w_cnt_sat = (r_stall_cnt == {CNT_W{1'b1}});
    // Only genuine stall cycles are counted; a flush in the same cycle wins.
    assign w_cnt_inc = if_idex.stall && !if_idex.flush && !w_cnt_sat;

    // Stage register: reset, then flush, then stall (hold), then load.
    // NOTE: reset is sampled on the clock edge only, so it lives inside the
    // edge-triggered branch; all state uses non-blocking assignments so every
    // register sees pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_wb     <= '0;
            r_m      <= '0;
            r_ex     <= '0;
            r_npc    <= '0;
            r_rdata1 <= '0;
            r_rdata2 <= '0;
            r_sext   <= '0;
            r_rt     <= '0;
            r_rd     <= '0;
            r_valid  <= 1'b0;
        end else if (if_idex.flush) begin
            r_wb     <= '0;
            r_m      <= '0;
            r_ex     <= '0;
            r_valid  <= 1'b0;
`ifdef IDEX_FLUSH_ZERO_DATA_EN
            r_npc    <= '0;
            r_rdata1 <= '0;
            r_rdata2 <= '0;
            r_sext   <= '0;
            r_rt     <= '0;
            r_rd     <= '0;
`else
            // Data fields hold; zero control already makes the bubble a NOP.
`endif
        end else if (!if_idex.stall) begin
            r_wb     <= w_wb_ld;
            r_m      <= w_m_ld;
            r_ex     <= w_ex_ld;
            r_npc    <= if_idex.npc;
            r_rdata1 <= if_idex.readdat1;
            r_rdata2 <= if_idex.readdat2;
            r_sext   <= if_idex.signext_out;
            r_rt     <= if_idex.instr_2016;
            r_rd     <= if_idex.instr_1511;
            r_valid  <= if_idex.in_valid;
        end
    end

    // Saturating count of stall cycles since reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_stall_cnt <= '0;
        end else if (w_cnt_inc) begin
            r_stall_cnt <= r_stall_cnt + 1'b1;
        end
    end

    assign if_idex.wb_ctlout     = r_wb;
    assign if_idex.m_ctlout      = r_m;
    assign if_idex.ex_ctlout     = r_ex;
    assign if_idex.npcout        = r_npc;
    assign if_idex.rdata1out     = r_rdata1;
    assign if_idex.rdata2out     = r_rdata2;
    assign if_idex.s_extendout   = r_sext;
    assign if_idex.instrout_2016 = r_rt;
    assign if_idex.instrout_1511 = r_rd;
    assign if_idex.valid_out     = r_valid;
    assign if_idex.stall_cnt     = r_stall_cnt;
endmodule

// File: tb/tb_id_ex_pipe_reg.sv
// Directed, table-driven bench for id_ex_pipe_reg (default parameters),
// plus a hand-written saturation sequence on a CNT_W=3 instance.
// Flush data expectations follow IDEX_FLUSH_ZERO_DATA_EN.
module tb_id_ex_pipe_reg;
`ifdef IDEX_FLUSH_ZERO_DATA_EN
    localparam bit ZD = 1'b1;
`else
    localparam bit ZD = 1'b0;
`endif

    typedef struct {
        logic        rst_n, stall, flush, in_valid;
        logic [1:0]  wb;
        logic [2:0]  m;
        logic [3:0]  ex;
        logic [31:0] npc, rd1, rd2, sx;
        logic [4:0]  rt, rd;
    } in_t;

    typedef struct {
        logic [1:0]  wb;
        logic [2:0]  m;
        logic [3:0]  ex;
        logic [31:0] npc, rd1, rd2, sx;
        logic [4:0]  rt, rd;
        logic        valid;
        logic [15:0] cnt;
    } exp_t;

    typedef struct {
        in_t  i;
        exp_t e;
    } vec_t;

    logic clk;
    logic rst_n;
    logic rst_n_s;
    int   n_checks = 0;
    int   n_errors = 0;

    id_ex_pipe_reg_if #(.CNT_W(16)) u_if ();
    id_ex_pipe_reg_if #(.CNT_W(3))  u_if_s ();

    id_ex_pipe_reg #(.CNT_W(16)) u_dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .if_idex (u_if.slave)
    );

    id_ex_pipe_reg #(.CNT_W(3)) u_dut_s (
        .clk     (clk),
        .rst_n   (rst_n_s),
        .if_idex (u_if_s.slave)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input in_t v);
        rst_n               = v.rst_n;
        u_if.stall          = v.stall;
        u_if.flush          = v.flush;
        u_if.in_valid       = v.in_valid;
        u_if.ctlwb_out      = v.wb;
        u_if.ctlm_out       = v.m;
        u_if.ctlex_out      = v.ex;
        u_if.npc            = v.npc;
        u_if.readdat1       = v.rd1;
        u_if.readdat2       = v.rd2;
        u_if.signext_out    = v.sx;
        u_if.instr_2016     = v.rt;
        u_if.instr_1511     = v.rd;
    endtask

    task automatic check_vec(input int idx, input exp_t e);
        string p;
        p = $sformatf("v%0d.", idx);
        check({p, "wb"},    64'(u_if.wb_ctlout),     64'(e.wb));
        check({p, "m"},     64'(u_if.m_ctlout),      64'(e.m));
        check({p, "ex"},    64'(u_if.ex_ctlout),     64'(e.ex));
        check({p, "npc"},   64'(u_if.npcout),        64'(e.npc));
        check({p, "rd1"},   64'(u_if.rdata1out),     64'(e.rd1));
        check({p, "rd2"},   64'(u_if.rdata2out),     64'(e.rd2));
        check({p, "sext"},  64'(u_if.s_extendout),   64'(e.sx));
        check({p, "rt"},    64'(u_if.instrout_2016), 64'(e.rt));
        check({p, "rd"},    64'(u_if.instrout_1511), 64'(e.rd));
        check({p, "valid"}, 64'(u_if.valid_out),     64'(e.valid));
        check({p, "cnt"},   64'(u_if.stall_cnt),     64'(e.cnt));
    endtask

    vec_t vecs[14];

    initial begin
        in_t  in_all, in_load, in_a, in_fl, in_bub, in_fo, in_max;
        exp_t e_zero, e_load, e_a, e_bub, e_max;

        // Stimulus records: rst_n, stall, flush, in_valid, wb, m, ex, npc, rd1, rd2, sx, rt, rd
        in_all  = '{1'b0, 1'b1, 1'b0, 1'b1, 2'd3, 3'd7, 4'hF, 32'hFFFF_FFFF, 32'h1111_1111,
                    32'h2222_2222, 32'h3333_3333, 5'h1F, 5'h1E};
        in_load = '{1'b1, 1'b0, 1'b0, 1'b1, 2'd1, 3'd2, 4'd3, 32'd4, 32'd5, 32'd6, 32'd7, 5'd8, 5'd9};
        in_a    = '{1'b1, 1'b1, 1'b0, 1'b1, 2'd2, 3'd5, 4'hA, 32'hA0, 32'hA1, 32'hA2, 32'hA3,
                    5'hA, 5'hB};
        in_fl   = in_a;
        in_fl.flush = 1'b1;
        in_bub  = '{1'b1, 1'b0, 1'b0, 1'b0, 2'd1, 3'd2, 4'd3, 32'h100, 32'h101, 32'h102, 32'h103,
                    5'd4, 5'd5};
        in_fo   = in_load;
        in_fo.flush = 1'b1;
        in_max  = '{1'b1, 1'b0, 1'b0, 1'b1, 2'd3, 3'd7, 4'hF, 32'hFFFF_FFFF, 32'hDEAD_BEEF,
                    32'h1234_5678, 32'hFFFF_8000, 5'h1F, 5'h1E};

        // Expected records: wb, m, ex, npc, rd1, rd2, sx, rt, rd, valid, cnt
        e_zero = '{2'd0, 3'd0, 4'd0, 32'd0, 32'd0, 32'd0, 32'd0, 5'd0, 5'd0, 1'b0, 16'd0};
        e_load = '{2'd1, 3'd2, 4'd3, 32'd4, 32'd5, 32'd6, 32'd7, 5'd8, 5'd9, 1'b1, 16'd0};
        e_a    = '{2'd2, 3'd5, 4'hA, 32'hA0, 32'hA1, 32'hA2, 32'hA3, 5'hA, 5'hB, 1'b1, 16'd3};
        e_bub  = '{2'd0, 3'd0, 4'd0, 32'h100, 32'h101, 32'h102, 32'h103, 5'd4, 5'd5, 1'b0, 16'd3};
        e_max  = '{2'd3, 3'd7, 4'hF, 32'hFFFF_FFFF, 32'hDEAD_BEEF, 32'h1234_5678, 32'hFFFF_8000,
                   5'h1F, 5'h1E, 1'b1, 16'd3};

        vecs[0].i = in_all;  vecs[0].e = e_zero;                 // reset, inputs busy
        vecs[1].i = in_all;  vecs[1].e = e_zero;                 // second reset edge
        vecs[2].i = in_load; vecs[2].e = e_load;                 // load 1..9
        vecs[3].i = in_a;    vecs[3].e = e_load; vecs[3].e.cnt = 16'd1; // stall holds
        vecs[4].i = in_a;    vecs[4].e = e_load; vecs[4].e.cnt = 16'd2;
        vecs[5].i = in_a;    vecs[5].e = e_load; vecs[5].e.cnt = 16'd3;
        // flush + stall: bubble, counter unchanged, data held or cleared
        vecs[6].i = in_fl;
        vecs[6].e = '{2'd0, 3'd0, 4'd0,
                      ZD ? 32'd0 : 32'd4, ZD ? 32'd0 : 32'd5, ZD ? 32'd0 : 32'd6,
                      ZD ? 32'd0 : 32'd7, ZD ? 5'd0 : 5'd8, ZD ? 5'd0 : 5'd9, 1'b0, 16'd3};
        vecs[7].i = in_a;    vecs[7].i.stall = 1'b0; vecs[7].e = e_a;  // stall dropped: capture
        vecs[8].i = in_bub;  vecs[8].e = e_bub;                  // in_valid=0 bubble
        // flush alone after the bubble: data held or cleared
        vecs[9].i = in_fo;
        vecs[9].e = '{2'd0, 3'd0, 4'd0,
                      ZD ? 32'd0 : 32'h100, ZD ? 32'd0 : 32'h101, ZD ? 32'd0 : 32'h102,
                      ZD ? 32'd0 : 32'h103, ZD ? 5'd0 : 5'd4, ZD ? 5'd0 : 5'd5, 1'b0, 16'd3};
        vecs[10].i = in_max; vecs[10].e = e_max;                 // all-ones style operands
        vecs[11].i = in_all; vecs[11].e = e_zero;                // reset mid-stall
        vecs[12].i = in_a;   vecs[12].e = e_zero; vecs[12].e.cnt = 16'd1; // stall after reset
        vecs[13].i = in_load; vecs[13].e = e_load; vecs[13].e.cnt = 16'd1; // first load

        // Saturation instance held in reset while the main table runs.
        rst_n_s          = 1'b0;
        u_if_s.stall     = 1'b0;
        u_if_s.flush     = 1'b0;
        u_if_s.in_valid  = 1'b0;
        u_if_s.ctlwb_out = '0;
        u_if_s.ctlm_out  = '0;
        u_if_s.ctlex_out = '0;
        u_if_s.npc       = '0;
        u_if_s.readdat1  = '0;
        u_if_s.readdat2  = '0;
        u_if_s.signext_out = '0;
        u_if_s.instr_2016  = '0;
        u_if_s.instr_1511  = '0;

        for (int k = 0; k < 14; k++) begin
            @(negedge clk);
            drive(vecs[k].i);
            @(posedge clk);
            #1;
            check_vec(k, vecs[k].e);
        end

        // Saturation: 3-bit counter stalls 10 edges, sticks at 7, then resets.
        @(negedge clk);
        rst_n_s = 1'b0;
        @(posedge clk);
        #1;
        check("sat.reset", 64'(u_if_s.stall_cnt), 64'd0);
        @(negedge clk);
        rst_n_s      = 1'b1;
        u_if_s.stall = 1'b1;
        for (int k = 1; k <= 10; k++) begin
            @(posedge clk);
            #1;
            check($sformatf("sat.cnt%0d", k), 64'(u_if_s.stall_cnt), 64'((k > 7) ? 7 : k));
        end
        // Stall + flush at saturation leaves it at 7 and inserts a bubble.
        @(negedge clk);
        u_if_s.flush = 1'b1;
        @(posedge clk);
        #1;
        check("sat.flush_cnt", 64'(u_if_s.stall_cnt), 64'd7);
        check("sat.flush_valid", 64'(u_if_s.valid_out), 64'd0);
        @(negedge clk);
        rst_n_s = 1'b0;
        @(posedge clk);
        #1;
        check("sat.post_reset", 64'(u_if_s.stall_cnt), 64'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
